// File: rtl/vga_plot_pkg.sv
// vga_plot_pkg: screen geometry, read FSM states and pixel address mapping shared by the plot sink
package vga_plot_pkg;

    localparam int SCR_W    = 160;
    localparam int SCR_H    = 120;
    localparam int FB_DEPTH = SCR_W * SCR_H;
    localparam int ADDR_W   = 15;

    typedef enum logic [2:0] {IDLE, SCAN, DRAIN, DONE, CLEAR} state_t;

    // Row-major address, formed at 32 bits so y*SCR_W cannot wrap before truncation
    function automatic logic [ADDR_W-1:0] xy_to_addr(input logic [7:0] x, input logic [6:0] y);
        return ADDR_W'(32'(y) * SCR_W + 32'(x));
    endfunction

endpackage

// File: rtl/vga_fb_ram.sv
// vga_fb_ram: simple dual-port framebuffer RAM, registered read with old-data read-during-write
module vga_fb_ram
    import vga_plot_pkg::*;
#(
    parameter int DEPTH = FB_DEPTH,
    parameter int AW    = ADDR_W,
    parameter int DW    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd,
    input  logic          re,
    input  logic [AW-1:0] ra,
    output logic [DW-1:0] q
);

    logic [DW-1:0] mem [DEPTH];

    // Write port; the array itself is never reset
    always_ff @(posedge clk) begin
        if (we) mem[wa] <= wd;
    end

    // Read register samples the array before this edge's write lands, and holds when not reading
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= '0;
        else if (re) q <= mem[ra];
    end

endmodule

// File: rtl/vga_plot_sink.sv
// vga_plot_sink: captures plotted pixels into a framebuffer and replays it as a raster stream.
// Optional macro VGA_PLOT_SINK_CLEAR_ON_RESET_EN zero-fills the framebuffer after reset release.
module vga_plot_sink
    import vga_plot_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       vga_x,
    input  logic [6:0]       vga_y,
    input  logic [2:0]       vga_colour,
    input  logic             vga_plot,
    input  logic             rd_start,
    output logic             rd_valid,
    output logic [7:0]       rd_x,
    output logic [6:0]       rd_y,
    output logic [2:0]       rd_colour,
    output logic             rd_done,
    output logic [CNT_W-1:0] plot_count,
    output logic [CNT_W-1:0] oob_count
);

    state_t            state;
    logic [7:0]        sx;
    logic [6:0]        sy;
    logic              clearing;
    logic              accept;
    logic              reject;
    logic              we;
    logic [ADDR_W-1:0] wa;
    logic [2:0]        wd;

`ifdef VGA_PLOT_SINK_CLEAR_ON_RESET_EN
    localparam state_t RST_STATE = CLEAR;
    logic [ADDR_W-1:0] clr_addr;
    assign clearing = state == CLEAR;
    assign wa       = clearing ? clr_addr : xy_to_addr(vga_x, vga_y);
`else
    localparam state_t RST_STATE = IDLE;
    assign clearing = 1'b0;
    assign wa       = xy_to_addr(vga_x, vga_y);
`endif

    assign accept = vga_plot && !clearing && vga_x < 8'(SCR_W) && vga_y < 7'(SCR_H);
    assign reject = vga_plot && !accept;
    assign we     = accept || clearing;
    assign wd     = clearing ? 3'd0 : vga_colour;

    vga_fb_ram u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we),
        .wa    (wa),
        .wd    (wd),
        .re    (state == SCAN),
        .ra    (xy_to_addr(sx, sy)),
        .q     (rd_colour)
    );

    // Saturating tallies of accepted and rejected plots
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            plot_count <= '0;
            oob_count  <= '0;
        end else begin
            if (accept && plot_count != '1) plot_count <= plot_count + CNT_W'(1);
            if (reject && oob_count != '1) oob_count <= oob_count + CNT_W'(1);
        end
    end

    // Replay FSM: raster scan issues one address per cycle; outputs trail the address by one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RST_STATE;
            sx       <= '0;
            sy       <= '0;
            rd_valid <= 1'b0;
            rd_done  <= 1'b0;
            rd_x     <= '0;
            rd_y     <= '0;
`ifdef VGA_PLOT_SINK_CLEAR_ON_RESET_EN
            clr_addr <= '0;
`endif
        end else begin
            rd_valid <= state == SCAN;
            if (state == SCAN) begin
                rd_x <= sx;
                rd_y <= sy;
            end
            case (state)
                IDLE: if (rd_start) begin
                    state <= SCAN;
                    sx    <= '0;
                    sy    <= '0;
                end
                SCAN: if (sx == 8'(SCR_W - 1)) begin
                    sx <= '0;
                    if (sy == 7'(SCR_H - 1)) state <= DRAIN;
                    else sy <= sy + 7'd1;
                end else begin
                    sx <= sx + 8'd1;
                end
                DRAIN: begin
                    state   <= DONE;
                    rd_done <= 1'b1;
                end
                DONE: if (!rd_start) begin
                    state   <= IDLE;
                    rd_done <= 1'b0;
                end
`ifdef VGA_PLOT_SINK_CLEAR_ON_RESET_EN
                CLEAR: begin
                    clr_addr <= clr_addr + ADDR_W'(1);
                    if (clr_addr == ADDR_W'(FB_DEPTH - 1)) state <= IDLE;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_plot_sink.sv
// tb_vga_plot_sink: randomized and directed checks of vga_plot_sink against a pixel-level model
`timescale 1ns/1ps
module tb_vga_plot_sink;

    localparam int W  = 160;
    localparam int H  = 120;
    localparam int FB = W * H;
`ifdef VGA_PLOT_SINK_CLEAR_ON_RESET_EN
    localparam int RST_MODE = 3;
    localparam int OOB0 = 10;
    localparam int EXP00 = 0;
    localparam int EXP57 = 0;
`else
    localparam int RST_MODE = 0;
    localparam int OOB0 = 0;
    localparam int EXP00 = 2;
    localparam int EXP57 = 3;
`endif

    logic        clk;
    logic        rst_n;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;
    logic        rd_start;
    logic        rd_valid;
    logic [7:0]  rd_x;
    logic [6:0]  rd_y;
    logic [2:0]  rd_colour;
    logic        rd_done;
    logic [15:0] plot_count;
    logic [15:0] oob_count;

    int checks = 0;
    int failures = 0;

    vga_plot_sink dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot),
        .rd_start   (rd_start),
        .rd_valid   (rd_valid),
        .rd_x       (rd_x),
        .rd_y       (rd_y),
        .rd_colour  (rd_colour),
        .rd_done    (rd_done),
        .plot_count (plot_count),
        .oob_count  (oob_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Pixel-level model: memory image, replay beat counter, plot tallies
    logic [2:0] m_mem [FB];
    bit         m_known [FB];
    int mode, k, clr;
    bit e_valid, e_done, e_known;
    int e_x, e_y, e_c, e_pc, e_oc;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode = RST_MODE; k = 0; clr = 0;
            e_valid = 0; e_done = 0; e_known = 1;
            e_x = 0; e_y = 0; e_c = 0; e_pc = 0; e_oc = 0;
        end else begin
            if (mode == 0) begin
                if (rd_start) begin mode = 1; k = 0; end
            end else if (mode == 1) begin
                k++;
                if (k <= FB) begin
                    e_valid = 1; e_x = (k - 1) % W; e_y = (k - 1) / W;
                    e_c = int'(m_mem[k - 1]); e_known = m_known[k - 1];
                end else begin
                    e_valid = 0; e_done = 1; mode = 2;
                end
            end else if (mode == 2) begin
                if (!rd_start) begin e_done = 0; mode = 0; end
            end
            if (vga_plot) begin
                if (mode != 3 && int'(vga_x) < W && int'(vga_y) < H) begin
                    m_mem[int'(vga_y) * W + int'(vga_x)] = vga_colour;
                    m_known[int'(vga_y) * W + int'(vga_x)] = 1;
                    if (e_pc < 65535) e_pc++;
                end else if (e_oc < 65535) e_oc++;
            end
            if (mode == 3) begin
                m_mem[clr] = 3'd0; m_known[clr] = 1; clr++;
                if (clr == FB) mode = 0;
            end
        end
    end

    // Cycle-by-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (rst_n) begin
            chk("rd_valid", int'(rd_valid), int'(e_valid));
            chk("rd_done", int'(rd_done), int'(e_done));
            chk("rd_x", int'(rd_x), e_x);
            chk("rd_y", int'(rd_y), e_y);
            if (e_known) chk("rd_colour", int'(rd_colour), e_c);
            chk("plot_count", int'(plot_count), e_pc);
            chk("oob_count", int'(oob_count), e_oc);
        end
    end

    task automatic drive(input int x, input int y, input int c);
        vga_x = 8'(x); vga_y = 7'(y); vga_colour = 3'(c); vga_plot = 1'b1;
        @(negedge clk);
        vga_plot = 1'b0;
    endtask

    task automatic find_beat(input int x, input int y, output bit ok);
        ok = 0;
        for (int i = 0; i < 20000 && !ok; i++) begin
            @(negedge clk);
            ok = rd_valid && int'(rd_x) == x && int'(rd_y) == y;
        end
    endtask

    task automatic wait_done();
        for (int i = 0; i < 20000 && !rd_done; i++) @(negedge clk);
        chk("done_wait", int'(rd_done), 1);
    endtask

    task automatic settle_clear();
`ifdef VGA_PLOT_SINK_CLEAR_ON_RESET_EN
        repeat (FB + 1) @(negedge clk);
`endif
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit ok;
        int beat, runs;
        bit prevv;
        rst_n = 0; vga_x = 0; vga_y = 0; vga_colour = 0; vga_plot = 0; rd_start = 0;
        repeat (3) @(negedge clk);
        chk("rst_valid", int'(rd_valid), 0);
        chk("rst_done", int'(rd_done), 0);
        chk("rst_x", int'(rd_x), 0);
        chk("rst_y", int'(rd_y), 0);
        chk("rst_colour", int'(rd_colour), 0);
        chk("rst_plot_count", int'(plot_count), 0);
        chk("rst_oob_count", int'(oob_count), 0);
        #2 rst_n = 1;
`ifdef VGA_PLOT_SINK_CLEAR_ON_RESET_EN
        repeat (10) drive(1, 1, 5);
        chk("clear_oob", int'(oob_count), 10);
        chk("clear_plot", int'(plot_count), 0);
        settle_clear();
`endif
        // Two in-bounds plots, then (0,0)=5 and two out-of-bounds plots
        drive(5, 7, 3);
        drive(159, 119, 6);
        chk("plot_count_2", int'(plot_count), 2);
        chk("oob_count_0", int'(oob_count), OOB0);
        drive(0, 0, 5);
        drive(160, 0, 7);
        drive(0, 120, 7);
        chk("oob_count_2", int'(oob_count), OOB0 + 2);
        chk("plot_count_3", int'(plot_count), 3);
        // Replay with a write to (0,0) in the cycle its read is issued
        rd_start = 1;
        @(negedge clk);
        vga_x = 0; vga_y = 0; vga_colour = 2; vga_plot = 1;
        @(negedge clk);
        vga_plot = 0;
        chk("first_beat_valid", int'(rd_valid), 1);
        chk("old_data_00", int'(rd_colour), 5);
        find_beat(5, 7, ok);
        chk("found_5_7", int'(ok), 1);
        chk("beat_5_7", int'(rd_colour), 3);
        find_beat(159, 119, ok);
        chk("found_159_119", int'(ok), 1);
        chk("beat_159_119", int'(rd_colour), 6);
        wait_done();
        rd_start = 0;
        @(negedge clk);
        // Second replay sees the new value, then reset after 100 beats
        rd_start = 1;
        @(negedge clk);
        @(negedge clk);
        chk("new_data_00", int'(rd_colour), 2);
        repeat (99) @(negedge clk);
        #2 rst_n = 0; rd_start = 0;
        #1;
        chk("midscan_valid", int'(rd_valid), 0);
        chk("midscan_done", int'(rd_done), 0);
        chk("midscan_plot", int'(plot_count), 0);
        chk("midscan_oob", int'(oob_count), 0);
        @(negedge clk);
        #2 rst_n = 1;
        settle_clear();
        // Replay after reset reproduces the stored image
        rd_start = 1;
        @(negedge clk);
        @(negedge clk);
        chk("post_rst_00", int'(rd_colour), EXP00);
        find_beat(5, 7, ok);
        chk("post_found_5_7", int'(ok), 1);
        chk("post_rst_5_7", int'(rd_colour), EXP57);
        wait_done();
        rd_start = 0;
        @(negedge clk);
        // Random scattered plots mixed with out-of-bounds ones, then a full fillscreen
        repeat (200) drive($urandom_range(0, 175), $urandom_range(0, 127), $urandom_range(0, 7));
        for (int p = 0; p < FB; p++) drive(p % W, p / W, (p % W) % 8);
        rd_start = 1;
        beat = 0; runs = 0; prevv = 0;
        for (int i = 0; i < FB + 100 && !rd_done; i++) begin
            @(negedge clk);
            if (rd_valid) begin
                chk("fill_colour", int'(rd_colour), (beat % W) % 8);
                if (!prevv) runs++;
                beat++;
            end
            if (!rd_done) prevv = rd_valid;
        end
        chk("fill_beats", beat, FB);
        chk("fill_runs", runs, 1);
        chk("fill_done", int'(rd_done), 1);
        chk("done_after_last", int'(prevv), 1);
        repeat (3) begin
            @(negedge clk);
            chk("done_held", int'(rd_done), 1);
        end
        rd_start = 0;
        @(negedge clk);
        chk("done_dropped", int'(rd_done), 0);
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_plot_sink.md
Name: vga_plot_sink

Overview:
- Receiving end of the pixel-plot interface (vga_x/vga_y/vga_colour/vga_plot) driven by fillscreen and the circle/reuleaux drawers.
- Captures every accepted plot into an internal 160x120x3 framebuffer.
- Later replays the framebuffer as a raster stream on a handshake-started read port, so drawers can be checked pixel-for-pixel in simulation and on-board.
- Sits where the VGA adapter would, as a drop-in sink.

Parameters:
- SCR_W, 160, screen width in pixels; vga_x is 8 bits.
- SCR_H, 120, screen height in pixels; vga_y is 7 bits.
- CNT_W, 16, width of the saturating plot_count and oob_count counters.

Ports:
- clk  in  1  system clock, CLOCK_50 domain.
- rst_n  in  1  asynchronous active-low reset.
- vga_x  in  8  plot x coordinate.
- vga_y  in  7  plot y coordinate.
- vga_colour  in  3  plot colour.
- vga_plot  in  1  plot strobe: one pixel per cycle when high, no backpressure.
- rd_start  in  1  level request to replay the framebuffer.
- rd_valid  out  1  rd_x/rd_y/rd_colour are valid this cycle.
- rd_x  out  8  replay x.
- rd_y  out  7  replay y.
- rd_colour  out  3  stored colour at (rd_x, rd_y).
- rd_done  out  1  replay complete; held until rd_start drops.
- plot_count  out  CNT_W  accepted in-bounds plots, saturating.
- oob_count  out  CNT_W  rejected out-of-bounds plots, saturating.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous, active-low (rst_n); all control registers clear immediately.
- Reset values: rd_valid=0, rd_done=0, rd_x=0, rd_y=0, rd_colour=0, plot_count=0, oob_count=0, FSM=IDLE.
- Framebuffer:
  - Simple dual-port RAM, SCR_W*SCR_H words x 3 bits.
  - addr = y*SCR_W + x, 15 bits, computed at full width before truncation.
  - Synchronous write, registered read.
  - RAM contents are not affected by reset.
- Write side (independent of FSM, every cycle):
  - vga_plot=1 with x<SCR_W and y<SCR_H: write colour; plot_count += 1, saturating at all-ones.
  - vga_plot=1 otherwise: no write; oob_count += 1, saturating.
  - vga_plot=0: no action.
  - Writes are accepted in every state, including during replay.
- Read FSM states: IDLE, SCAN, DRAIN, DONE.
  - IDLE: rd_start=1 -> SCAN; scan counters (sx, sy) = (0, 0).
  - SCAN: issue a read of (sx, sy) each cycle. Order is row-major: sx increments first; at sx=SCR_W-1 it wraps to 0 and sy increments. After issuing (SCR_W-1, SCR_H-1) -> DRAIN.
  - DRAIN: one cycle, so the last RAM read emerges -> DONE.
  - DONE: rd_done=1; rd_start=0 -> IDLE with rd_done=0 on the next edge.
- Read latency: rd_valid and data appear exactly 1 cycle after the address is issued.
  - rd_valid is high for exactly SCR_W*SCR_H consecutive cycles (19200).
  - First valid output is (0,0) on the 2nd cycle after SCAN entry.
  - rd_x/rd_y are the registered address copies aligned with rd_colour.
  - rd_x/rd_y/rd_colour hold their last values when rd_valid=0.
- rd_start dropped mid-SCAN: ignored; the scan completes. DONE exits immediately if rd_start is already low.
- Read-during-write to the same address in the same cycle returns the OLD data. A write lands for all later reads.
- Reset mid-SCAN: FSM returns to IDLE, rd_valid=0 at once, counters clear, RAM keeps its contents.

Optional Feature:
- Macro: VGA_PLOT_SINK_CLEAR_ON_RESET_EN.
- Defined:
  - Extra state CLEAR entered on reset release. Writes 0 to all 19200 addresses, one per cycle, in ascending address order, then goes to IDLE.
  - While in CLEAR, rd_start is ignored.
  - Incoming plots are dropped: not written, not counted in plot_count, counted in oob_count.
- Undefined: no CLEAR state; the FSM starts in IDLE and RAM contents are undefined (X in simulation) until written.

Decomposition:
- Package vga_plot_pkg:
  - localparams SCR_W=160, SCR_H=120, FB_DEPTH=19200, ADDR_W=15.
  - typedef enum logic [2:0] state_t {IDLE, SCAN, DRAIN, DONE, CLEAR}.
  - function xy_to_addr(x, y).
- One sub-module: vga_fb_ram, the simple dual-port RAM with registered read, inferable as M10K, old-data read-during-write.

Test Plan:
- Reset then plot (5,7,colour 3), (159,119,colour 6), one per cycle; rd_start=1 -> at the replay beat for (5,7) rd_colour=3, and for (159,119) rd_colour=6; plot_count=2, oob_count=0.
- Plot x=160,y=0 and x=0,y=120, colour 7 -> no RAM change at (0,0); oob_count=2; plot_count unchanged.
- Drive the fillscreen pattern (colour = x%8 for all 19200 pixels), then replay -> every beat has rd_colour = rd_x%8; rd_valid high for exactly 19200 cycles; rd_done rises the cycle after the last beat and stays high until rd_start=0.
- Write (0,0)=5 and (0,0)=2 in the same cycle the scan reads (0,0) -> first beat returns 5 (old data); a second replay returns 2.
- Assert rd_start, pull rst_n low after 100 beats -> rd_valid=0 and counters=0 immediately; a replay after reset reproduces the pre-reset contents.
- With VGA_PLOT_SINK_CLEAR_ON_RESET_EN: assert a plot during the first 10 cycles after reset -> oob_count=10 and plot_count=0; after 19200 cycles a replay shows all pixels = 0.
